// File: rtl/sqrt_iter32.sv
// sqrt_iter32: sequential 32-bit unsigned integer square root.
// Non-restoring algorithm, one root bit per cycle, 16 CALC cycles plus one
// FIX cycle that corrects a negative final partial remainder.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     request, sampled only while idle (busy=0)
//   radicand  32-bit unsigned operand, captured on the accepted start edge
//   busy      high from the accepting edge until the FIX edge
//   done      one-cycle pulse, root/rem valid
//   root      floor(sqrt(radicand)), held until the next result
//   rem       radicand - root*root, held until the next result
module sqrt_iter32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] radicand,
  output logic        busy,
  output logic        done,
  output logic [15:0] root,
  output logic [16:0] rem
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_nxt;
  logic [31:0] d;
  logic [17:0] r;
  logic [15:0] q;
  logic [3:0]  cnt;

  logic [1:0]  pair;
  logic        sub;
  logic [17:0] add_a, add_b, add_sum;

  assign pair = {d[{cnt, 1'b1}], d[{cnt, 1'b0}]};

  // One shared 18-bit adder: CALC uses it for the add/subtract step, FIX
  // reuses it (sub=0) for the negative-remainder correction.
  always_comb begin
    sub   = 1'b0;
    add_a = '0;
    add_b = '0;
    case (state)
      CALC: begin
        sub   = ~r[17];
        add_a = {r[15:0], pair};
        add_b = r[17] ? {q, 2'b11} : {q, 2'b01};
      end
      FIX: begin
        add_a = r;
        add_b = {1'b0, q, 1'b1};
      end
      default: ;
    endcase
    add_sum = add_a + (add_b ^ {18{sub}}) + {17'b0, sub};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == 4'd0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d    <= '0;
      r    <= '0;
      q    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      root <= '0;
      rem  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            d    <= radicand;
            r    <= '0;
            q    <= '0;
            cnt  <= 4'd15;
            busy <= 1'b1;
          end
        end
        CALC: begin
          r   <= add_sum;
          q   <= {q[14:0], ~add_sum[17]};
          cnt <= (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        end
        FIX: begin
          if (r[17]) begin
            r   <= add_sum;
            rem <= add_sum[16:0];
          end else begin
            rem <= r[16:0];
          end
          root <= q;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
